// File: rtl/sdp_memory_arbiter.sv
// sdp_memory_arbiter
//   Shares one simple dual-port memory wrapper between N_REQ requesters.
//   Write and read ports are arbitrated independently (round-robin), so one
//   write and one read may be granted per cycle. Read data comes back one
//   cycle after the grant, tagged with the requester index.
//
//   Build option: define SDP_ARB_FIXED_PRIO_EN for fixed priority (lowest
//   asserted index wins, no pointers). Default build is round-robin.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   wr_valid/ready, wr_addr, wr_data   per-requester write channel (packed)
//   rd_valid/ready, rd_addr            per-requester read channel (packed)
//   rsp_valid, rsp_id, rsp_data        read response, no backpressure
//   mem_addr_d, mem_d, mem_en          memory write pins
//   mem_addr_q, mem_q                  memory read pins (q one cycle later)
module sdp_memory_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int N_REQ = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       wr_valid,
    output logic [N_REQ-1:0]       wr_ready,
    input  logic [N_REQ*AW-1:0]    wr_addr,
    input  logic [N_REQ*WIDTH-1:0] wr_data,
    input  logic [N_REQ-1:0]       rd_valid,
    output logic [N_REQ-1:0]       rd_ready,
    input  logic [N_REQ*AW-1:0]    rd_addr,
    output logic                   rsp_valid,
    output logic [IW-1:0]          rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [AW-1:0]          mem_addr_d,
    output logic [WIDTH-1:0]       mem_d,
    output logic                   mem_en,
    output logic [AW-1:0]          mem_addr_q,
    input  logic [WIDTH-1:0]       mem_q
);

    logic [AW-1:0]    wa [N_REQ];
    logic [WIDTH-1:0] wd [N_REQ];
    logic [AW-1:0]    ra [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign wa[g] = wr_addr[g*AW +: AW];
        assign wd[g] = wr_data[g*WIDTH +: WIDTH];
        assign ra[g] = rd_addr[g*AW +: AW];
    end

    logic [IW-1:0] wptr, rptr;
    logic          wr_found, rd_found, rd_gnt;
    logic [IW-1:0] wr_idx, rd_idx, sel;
    int unsigned   idx;
    logic [AW-1:0] last_raddr;

    // Scan requesters starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        wr_found = 1'b0;
        wr_idx   = '0;
        rd_found = 1'b0;
        rd_idx   = '0;
        idx      = 0;
        sel      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(wptr) + i;
            if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
            sel = IW'(idx);
            if (!wr_found && wr_valid[sel]) begin
                wr_found = 1'b1;
                wr_idx   = sel;
            end
            idx = 32'(rptr) + i;
            if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
            sel = IW'(idx);
            if (!rd_found && rd_valid[sel]) begin
                rd_found = 1'b1;
                rd_idx   = sel;
            end
        end
        if (rst) begin
            wr_found = 1'b0;
            rd_found = 1'b0;
        end
    end

    // A read colliding with the same-cycle write address is deferred so that
    // it observes the new data once the write has landed.
    assign rd_gnt = rd_found && !(wr_found && (ra[rd_idx] == wa[wr_idx]));

    always_comb begin
        wr_ready   = '0;
        rd_ready   = '0;
        mem_en     = 1'b0;
        mem_addr_d = '0;
        mem_d      = '0;
        mem_addr_q = last_raddr;
        if (wr_found) begin
            wr_ready[wr_idx] = 1'b1;
            mem_en           = 1'b1;
            mem_addr_d       = wa[wr_idx];
            mem_d            = wd[wr_idx];
        end
        if (rd_gnt) begin
            rd_ready[rd_idx] = 1'b1;
            mem_addr_q       = ra[rd_idx];
        end
    end

`ifdef SDP_ARB_FIXED_PRIO_EN
    assign wptr = '0;
    assign rptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_found) wptr <= (wr_idx == IW'(N_REQ - 1)) ? '0 : wr_idx + 1'b1;
            if (rd_gnt)   rptr <= (rd_idx == IW'(N_REQ - 1)) ? '0 : rd_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            last_raddr <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
        end else begin
            rsp_valid <= rd_gnt;
            if (rd_gnt) begin
                rsp_id     <= rd_idx;
                last_raddr <= ra[rd_idx];
            end
        end
    end

    assign rsp_data = mem_q;

endmodule

// File: tb/tb_sdp_memory_arbiter.sv
module tb_sdp_memory_arbiter;

    localparam int W     = 8;
    localparam int DEPTH = 256;
    localparam int N     = 4;
    localparam int AW    = 8;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      wr_valid, wr_ready, rd_valid, rd_ready;
    logic [N*AW-1:0]   wr_addr, rd_addr;
    logic [N*W-1:0]    wr_data;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_data;
    logic [AW-1:0]     mem_addr_d, mem_addr_q;
    logic [W-1:0]      mem_d, mem_q;
    logic              mem_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdp_memory_arbiter #(.WIDTH(W), .DEPTH(DEPTH), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mem_addr_d(mem_addr_d), .mem_d(mem_d), .mem_en(mem_en),
        .mem_addr_q(mem_addr_q), .mem_q(mem_q)
    );

    // Memory wrapper stand-in: synchronous write, registered read.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) mem[mem_addr_d] <= mem_d;
        mem_q <= mem[mem_addr_q];
    end

    // Reference model state
    logic [W-1:0]  ref_mem [DEPTH];
    int            wp = 0, rp = 0;
    logic [AW-1:0] lraddr = '0;
    logic          pend_valid = 1'b0;
    int            pend_id = 0;
    logic [W-1:0]  pend_data = '0;
    int            ewg, erg;
    logic [N-1:0]  exp_wr_ready, exp_rd_ready;
    logic [AW-1:0] exp_addr_q;

    function automatic logic [AW-1:0] wa_of(int i); return wr_addr[i*AW +: AW]; endfunction
    function automatic logic [W-1:0]  wd_of(int i); return wr_data[i*W +: W];   endfunction
    function automatic logic [AW-1:0] ra_of(int i); return rd_addr[i*AW +: AW]; endfunction

    function automatic void model_eval();
        ewg = -1;
        erg = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (ewg < 0 && wr_valid[(wp + k) % N]) ewg = (wp + k) % N;
                if (erg < 0 && rd_valid[(rp + k) % N]) erg = (rp + k) % N;
            end
        end
        if (ewg >= 0 && erg >= 0 && ra_of(erg) == wa_of(ewg)) erg = -1;
        exp_wr_ready = (ewg >= 0) ? N'(1 << ewg) : '0;
        exp_rd_ready = (erg >= 0) ? N'(1 << erg) : '0;
        exp_addr_q   = (erg >= 0) ? ra_of(erg) : lraddr;
    endfunction

    task automatic tick();
        model_eval();
        if (rst) begin
            wp = 0; rp = 0; lraddr = '0; pend_valid = 1'b0; pend_id = 0;
        end else begin
            pend_valid = (erg >= 0);
            if (erg >= 0) begin
                pend_id   = erg;
                pend_data = ref_mem[ra_of(erg)];
                lraddr    = ra_of(erg);
`ifndef SDP_ARB_FIXED_PRIO_EN
                rp = (erg + 1) % N;
`endif
            end
            if (ewg >= 0) begin
                ref_mem[wa_of(ewg)] = wd_of(ewg);
`ifndef SDP_ARB_FIXED_PRIO_EN
                wp = (ewg + 1) % N;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (wr_ready !== '0 || rd_ready !== '0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_grants got wr=%b rd=%b en=%b exp 0", wr_ready, rd_ready, mem_en);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%0d exp 0/0", rsp_valid, rsp_id);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_addr_d !== '0 || mem_d !== '0 || mem_addr_q !== '0) begin
            errors++;
            $display("FAIL reset_mem_pins got ad=%0d d=%0d aq=%0d exp 0", mem_addr_d, mem_d, mem_addr_q);
        end
    endtask

    task automatic test_single();
        do_reset();
        wr_valid = 4'b0010; wr_addr[1*AW +: AW] = 8'd3; wr_data[1*W +: W] = 8'd42;
        #1;
        checks++;
        if (wr_ready !== 4'b0010 || mem_en !== 1'b1 || mem_addr_d !== 8'd3 || mem_d !== 8'd42) begin
            errors++;
            $display("FAIL single_write got rdy=%b en=%b a=%0d d=%0d exp 0010/1/3/42", wr_ready, mem_en, mem_addr_d, mem_d);
        end
        tick();
        wr_valid = '0; rd_valid = 4'b0010; rd_addr[1*AW +: AW] = 8'd3;
        #1;
        checks++;
        if (rd_ready !== 4'b0010 || mem_addr_q !== 8'd3) begin
            errors++;
            $display("FAIL single_read_grant got rdy=%b aq=%0d exp 0010/3", rd_ready, mem_addr_q);
        end
        tick();
        rd_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'd42) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d d=%0d exp 1/1/42", rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        wr_valid = '1;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef SDP_ARB_FIXED_PRIO_EN
            exp = 4'b0001;
`else
            exp = N'(1 << (i % N));
`endif
            checks++;
            if (wr_ready !== exp) begin
                errors++;
                $display("FAIL rr_write[%0d] got=%b exp=%b", i, wr_ready, exp);
            end
            tick();
        end
        wr_valid = '0;
        for (int j = 0; j < N; j++) rd_addr[j*AW +: AW] = AW'(100 + j);
        rd_valid = '1;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef SDP_ARB_FIXED_PRIO_EN
            exp = 4'b0001;
`else
            exp = N'(1 << (i % N));
`endif
            checks++;
            if (rd_ready !== exp) begin
                errors++;
                $display("FAIL rr_read[%0d] got=%b exp=%b", i, rd_ready, exp);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_read_rsp[%0d] got=%b exp=1", i, rsp_valid);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_concurrent();
        do_reset();
        wr_valid = 4'b0001; wr_addr[0 +: AW] = 8'd10; wr_data[0 +: W] = 8'd7;
        rd_valid = 4'b0100; rd_addr[2*AW +: AW] = 8'd3;
        #1;
        checks++;
        if (wr_ready !== 4'b0001 || rd_ready !== 4'b0100) begin
            errors++;
            $display("FAIL concurrent_grant got wr=%b rd=%b exp 0001/0100", wr_ready, rd_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'd42) begin
            errors++;
            $display("FAIL concurrent_rsp got v=%b id=%0d d=%0d exp 1/2/42", rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        wr_valid = 4'b0001; wr_addr[0 +: AW] = 8'd5; wr_data[0 +: W] = 8'd41;
        rd_valid = 4'b0010; rd_addr[1*AW +: AW] = 8'd5;
        #1;
        checks++;
        if (wr_ready !== 4'b0001 || rd_ready !== 4'b0000) begin
            errors++;
            $display("FAIL hazard_block got wr=%b rd=%b exp 0001/0000", wr_ready, rd_ready);
        end
        tick();
        wr_valid = '0;
        #1;
        checks++;
        if (rd_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hazard_retry got rd=%b v=%b exp 0010/0", rd_ready, rsp_valid);
        end
        tick();
        rd_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'd41) begin
            errors++;
            $display("FAIL hazard_rsp got v=%b id=%0d d=%0d exp 1/1/41", rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        wr_valid = 4'b1000; wr_addr[3*AW +: AW] = 8'd20;
        rd_valid = 4'b1000; rd_addr[3*AW +: AW] = 8'd21;
        #1;
        checks++;
        if (wr_ready !== 4'b1000 || rd_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_req3 got wr=%b rd=%b exp 1000/1000", wr_ready, rd_ready);
        end
        tick();
        wr_valid = 4'b1001; rd_valid = 4'b1001; rd_addr[0 +: AW] = 8'd22;
        #1;
        checks++;
        if (wr_ready !== 4'b0001 || rd_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_req0_first got wr=%b rd=%b exp 0001/0001", wr_ready, rd_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        rd_valid = 4'b0001; rd_addr[0 +: AW] = 8'd3; rd_addr[1*AW +: AW] = 8'd4;
        tick();
        rd_valid = 4'b0011; wr_valid = 4'b0100; wr_addr[2*AW +: AW] = 8'd9;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_ready !== '0 || wr_ready !== '0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_grant got rd=%b wr=%b en=%b exp 0", rd_ready, wr_ready, mem_en);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_rsp_during got=%b exp=0", rsp_valid);
        end
        rst = 1'b0;
        rd_valid = 4'b0110; wr_valid = 4'b0110; wr_addr[1*AW +: AW] = 8'd11;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rd_ready !== 4'b0010 || wr_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_after got v=%b rd=%b wr=%b exp 0/0010/0010", rsp_valid, rd_ready, wr_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] keep_w, keep_r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            #1;
            model_eval();
            checks++;
            if (wr_ready !== exp_wr_ready || rd_ready !== exp_rd_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d] got wr=%b rd=%b exp wr=%b rd=%b", c, wr_ready, rd_ready, exp_wr_ready, exp_rd_ready);
            end
            checks++;
            if (mem_en !== (ewg >= 0) ||
                mem_addr_d !== ((ewg >= 0) ? wa_of(ewg) : '0) ||
                mem_d !== ((ewg >= 0) ? wd_of(ewg) : '0) ||
                mem_addr_q !== exp_addr_q) begin
                errors++;
                $display("FAIL rand_mem_pins[%0d] got en=%b ad=%0d d=%0d aq=%0d exp_aq=%0d", c, mem_en, mem_addr_d, mem_d, mem_addr_q, exp_addr_q);
            end
            checks++;
            if (rsp_valid !== pend_valid ||
                (pend_valid && (rsp_id !== IW'(pend_id) || rsp_data !== pend_data))) begin
                errors++;
                $display("FAIL rand_rsp[%0d] got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d", c, rsp_valid, rsp_id, rsp_data, pend_valid, pend_id, pend_data);
            end
            keep_w = wr_valid & ~exp_wr_ready;
            keep_r = rd_valid & ~exp_rd_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!keep_w[i]) begin
                    wr_valid[i] = 1'($urandom_range(0, 1));
                    wr_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    wr_data[i*W +: W] = W'($urandom);
                end
                if (!keep_r[i]) begin
                    rd_valid[i] = 1'($urandom_range(0, 1));
                    rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_concurrent();
        test_hazard();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
